// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and access legality check for the LSU
package lsu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_MERGE, S_WR, S_LDRSP, S_RESP} lsu_state_e;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] RWTYP_WORD = 3'b010;
  function automatic logic lsu_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    return (we ? f3 > F3_W : (f3 == 3'b011 || f3[2:1] == 2'b11)) ||
           (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: MEM-stage request/response handshake between core and LSU
interface lsu_ctrl_if;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [2:0] req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_we, req_funct3, req_addr, req_wdata,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: load lane extraction/extension and sub-word store merge on a RAM word
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged_word
);
  logic [4:0] w_bsh;
  logic [4:0] w_hsh;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  assign w_bsh = {i_addr, 3'b000};
  assign w_hsh = {i_addr[1], 4'b0000};
  assign w_byte = 8'(i_word >> w_bsh);
  assign w_half = 16'(i_word >> w_hsh);
  assign o_load_data = i_funct3 == F3_B  ? {{24{w_byte[7]}}, w_byte} :
                       i_funct3 == F3_H  ? {{16{w_half[15]}}, w_half} :
                       i_funct3 == F3_BU ? {24'b0, w_byte} :
                       i_funct3 == F3_HU ? {16'b0, w_half} : i_word;
  assign o_merged_word = i_funct3[0] ?
    (i_word & ~(32'h0000_FFFF << w_hsh)) | ({16'b0, i_wdata} << w_hsh) :
    (i_word & ~(32'h0000_00FF << w_bsh)) | ({24'b0, i_wdata[7:0]} << w_bsh);
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller driving a word-wide spram
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  lsu_ctrl_if.slave                 bus,
  output logic [RAM_ADDR_WIDTH-1:0] ram_address,
  output logic                      ram_rden,
  output logic                      ram_wren,
  output logic [DATA_WIDTH-1:0]     ram_data,
  output logic [2:0]                ram_rwtyp,
  input  logic [DATA_WIDTH-1:0]     ram_q
);
  lsu_state_e r_state;
  lsu_state_e w_next;
  logic r_we;
  logic [2:0] r_f3;
  logic [RAM_ADDR_WIDTH+1:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] w_load;
  logic [31:0] w_merged;
  lsu_lane u_lane (
    .i_word(ram_q),
    .i_addr(r_addr[1:0]),
    .i_funct3(r_f3),
    .i_wdata(r_wdata[15:0]),
    .o_load_data(w_load),
    .o_merged_word(w_merged)
  );
  // state register and request latch, captured on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we <= 1'b0;
      r_f3 <= '0;
      r_addr <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.req_valid) begin
        r_we <= bus.req_we;
        r_f3 <= bus.req_funct3;
        r_addr <= bus.req_addr[RAM_ADDR_WIDTH+1:0];
        r_wdata <= bus.req_wdata;
      end
    end
  end
  // next state: errors answer directly, SW skips the read, sub-word stores merge
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.req_valid)
        w_next = lsu_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]) ? S_RESP :
                 (bus.req_we && bus.req_funct3 == F3_W) ? S_WR : S_RD;
      S_RD: w_next = r_we ? S_MERGE : S_LDRSP;
      S_MERGE, S_WR: w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  assign bus.req_ready = r_state == S_IDLE && !rst;
  assign bus.rsp_valid = r_state == S_LDRSP || r_state == S_RESP;
  assign bus.rsp_rdata = r_state == S_LDRSP ? w_load : '0;
  assign bus.rsp_err = r_state == S_RESP && lsu_err(r_we, r_f3, r_addr[1:0]);
  assign ram_address = r_addr[RAM_ADDR_WIDTH+1:2];
  assign ram_rden = r_state == S_RD;
  assign ram_wren = r_state == S_MERGE || r_state == S_WR;
  assign ram_data = r_state == S_MERGE ? w_merged : r_state == S_WR ? r_wdata : '0;
  assign ram_rwtyp = RWTYP_WORD;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl against a byte-level memory model
module tb_lsu_ctrl;
  import lsu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] ram_address;
  logic ram_rden, ram_wren;
  logic [31:0] ram_data;
  logic [31:0] ram_q = '0;
  logic [2:0] ram_rwtyp;
  logic [31:0] mem [0:65535];
  logic [7:0] sb [0:255];
  logic bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  int checks = 0;
  int failures = 0;

  lsu_ctrl_if bus();
  lsu_ctrl #(.RAM_ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_address(ram_address), .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_data(ram_data), .ram_rwtyp(ram_rwtyp), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rden) ram_q <= mem[ram_address];
    if (ram_wren) mem[ram_address] <= ram_data;
    if (bd_we) mem[bd_addr] <= bd_data;
  end

  task automatic set_word(input int w, input logic [31:0] v);
    bd_we = 1'b1; bd_addr = 16'(w); bd_data = v;
    for (int i = 0; i < 4; i++) sb[4*w+i] = 8'(v >> (8*i));
    @(posedge clk); #1 bd_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic e, output logic [31:0] rd, output int lat, output logic [31:0] ww);
    int size, idx;
    logic [31:0] v;
    size = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    e = (we ? f3 > 3'd2 : (f3 == 3'd3 || f3 >= 3'd6)) || (int'(a[1:0]) % size != 0);
    idx = int'(a[7:0]);
    rd = '0; ww = '0; lat = 1;
    if (e) return;
    if (!we) begin
      v = '0;
      for (int i = 0; i < size; i++) v |= 32'(sb[idx+i]) << (8*i);
      if (!f3[2] && size < 4 && v[8*size-1]) v |= 32'hFFFF_FFFF << (8*size);
      rd = v; lat = 2;
    end else begin
      for (int i = 0; i < size; i++) sb[idx+i] = 8'(wd >> (8*i));
      lat = size == 4 ? 2 : 3;
      for (int i = 0; i < 4; i++) ww |= 32'(sb[(idx & ~3)+i]) << (8*i);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err, output int lat, output int rd_cyc,
                        output int wr_cyc, output logic [31:0] wdat, output logic [15:0] raddr, output logic both);
    int n = 0;
    rdata = '0; err = 1'b0; lat = -1; rd_cyc = -1; wr_cyc = -1; wdat = '0; raddr = '0; both = 1'b0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      both |= ram_rden & ram_wren;
      if (ram_rden && rd_cyc < 0) begin rd_cyc = c; raddr = ram_address; end
      if (ram_wren) begin wr_cyc = c; wdat = ram_data; end
      if (bus.rsp_valid) begin lat = c; rdata = bus.rsp_rdata; err = bus.rsp_err; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, ram_rden, ram_wren} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {bus.req_ready, bus.rsp_valid, bus.rsp_err, ram_rden, ram_wren});
    end
    checks++;
    if ({bus.rsp_rdata, ram_data, ram_address} !== 80'b0) begin
      failures++; $display("FAIL reset_data rdata=%h ram_data=%h addr=%h exp=0", bus.rsp_rdata, ram_data, ram_address);
    end
    checks++;
    if (ram_rwtyp !== 3'b010) begin failures++; $display("FAIL rwtyp got=%b exp=010", ram_rwtyp); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_lw;
    logic [31:0] rd, wd; logic e, both; int lat, rc, wc; logic [15:0] ra;
    set_word(4, 32'hDEADBEEF);
    do_req(1'b0, F3_W, 32'h10, 32'h0, rd, e, lat, rc, wc, wd, ra, both);
    checks++;
    if (rc !== 1 || ra !== 16'd4) begin failures++; $display("FAIL lw_read cyc=%0d addr=%h exp cyc=1 addr=4", rc, ra); end
    checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || e !== 1'b0) begin
      failures++; $display("FAIL lw_rsp lat=%0d rdata=%h err=%b exp lat=2 rdata=deadbeef err=0", lat, rd, e);
    end
  endtask

  task automatic test_load_ext;
    logic [2:0] f3s [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] adr [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    logic [31:0] rd, wd; logic e, both; int lat, rc, wc; logic [15:0] ra;
    set_word(4, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3s[i], adr[i], 32'h0, rd, e, lat, rc, wc, wd, ra, both);
      checks++;
      if (rd !== exps[i] || lat !== 2 || e !== 1'b0) begin
        failures++; $display("FAIL load_ext f3=%b rdata=%h lat=%0d exp rdata=%h lat=2", f3s[i], rd, lat, exps[i]);
      end
    end
  endtask

  task automatic test_sb;
    logic [31:0] rd, wd, mr, mw; logic e, me, both; int lat, ml, rc, wc; logic [15:0] ra;
    set_word(8, 32'h11223344);
    model(1'b1, F3_B, 32'h21, 32'h0000_00AA, me, mr, ml, mw);
    do_req(1'b1, F3_B, 32'h21, 32'h0000_00AA, rd, e, lat, rc, wc, wd, ra, both);
    checks++;
    if (rc !== 1 || wc !== 2 || wd !== 32'h1122AA44) begin
      failures++; $display("FAIL sb_rmw rd_cyc=%0d wr_cyc=%0d data=%h exp 1 2 1122aa44", rc, wc, wd);
    end
    checks++;
    if (lat !== 3 || e !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL sb_rsp lat=%0d err=%b rdata=%h exp 3 0 0", lat, e, rd); end
    do_req(1'b0, F3_W, 32'h20, 32'h0, rd, e, lat, rc, wc, wd, ra, both);
    checks++;
    if (rd !== 32'h1122AA44) begin failures++; $display("FAIL sb_readback got=%h exp=1122aa44", rd); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd, wd; logic e, both; int lat, rc, wc; logic [15:0] ra;
    logic [2:0] f3s [2] = '{F3_W, F3_H};
    logic wes [2] = '{1'b0, 1'b1};
    logic [31:0] adr [2] = '{32'h2, 32'h5};
    for (int i = 0; i < 2; i++) begin
      do_req(wes[i], f3s[i], adr[i], 32'h5555_5555, rd, e, lat, rc, wc, wd, ra, both);
      checks++;
      if (rc !== -1 || wc !== -1 || lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin
        failures++; $display("FAIL misaligned%0d rd_cyc=%0d wr_cyc=%0d lat=%0d err=%b rdata=%h exp -1 -1 1 1 0", i, rc, wc, lat, e, rd);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v, mr, mw; logic me; int ml, n = 0;
    v = $urandom;
    model(1'b1, F3_W, 32'h30, v, me, mr, ml, mw);
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W; bus.req_addr = 32'h30; bus.req_wdata = v;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || ram_wren !== 1'b1 || ram_data !== v) begin
      failures++; $display("FAIL b2b_c1 ready=%b wren=%b data=%h exp 0 1 %h", bus.req_ready, ram_wren, ram_data, v);
    end
    bus.req_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin
      failures++; $display("FAIL b2b_c2 ready=%b valid=%b err=%b exp 0 1 0", bus.req_ready, bus.rsp_valid, bus.rsp_err);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_c3 ready=%b valid=%b exp 1 0", bus.req_ready, bus.rsp_valid);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (ram_rden !== 1'b1 || ram_address !== 16'd12) begin
      failures++; $display("FAIL b2b_c4 rden=%b addr=%h exp 1 000c", ram_rden, ram_address);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== v) begin
      failures++; $display("FAIL b2b_c5 valid=%b rdata=%h exp 1 %h", bus.rsp_valid, bus.rsp_rdata, v);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_H; bus.req_addr = 32'h6; bus.req_wdata = 32'h1234;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_wren !== 1'b1) begin failures++; $display("FAIL rstmid_merge wren=%b exp 1", ram_wren); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, ram_rden, ram_wren} !== 5'b0 ||
        {bus.rsp_rdata, ram_data, ram_address} !== 80'b0) begin
      failures++; $display("FAIL rstmid_outputs flags=%b rdata=%h data=%h addr=%h exp all 0",
        {bus.req_ready, bus.rsp_valid, bus.rsp_err, ram_rden, ram_wren}, bus.rsp_rdata, ram_data, ram_address);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_idle ready=%b valid=%b exp 1 0", bus.req_ready, bus.rsp_valid);
    end
    set_word(1, $urandom);
  endtask

  task automatic test_random;
    logic [31:0] rd, wd, a, v, mr, mw; logic e, me, both, we; logic [2:0] f3; int lat, ml, rc, wc, erc, ewc; logic [15:0] ra;
    for (int it = 0; it < 80; it++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; a[17:8] = '0;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      v = $urandom;
      model(we, f3, a, v, me, mr, ml, mw);
      erc = (me || (we && f3 == F3_W)) ? -1 : 1;
      ewc = (me || !we) ? -1 : (f3 == F3_W ? 1 : 2);
      do_req(we, f3, a, v, rd, e, lat, rc, wc, wd, ra, both);
      checks++;
      if (e !== me || lat !== ml || rd !== mr) begin
        failures++; $display("FAIL rand_rsp we=%b f3=%b a=%h err=%b lat=%0d rdata=%h exp %b %0d %h", we, f3, a, e, lat, rd, me, ml, mr);
      end
      checks++;
      if (rc !== erc || wc !== ewc || both !== 1'b0) begin
        failures++; $display("FAIL rand_ram we=%b f3=%b a=%h rd_cyc=%0d wr_cyc=%0d both=%b exp %0d %0d 0", we, f3, a, rc, wc, both, erc, ewc);
      end
      if (erc == 1) begin
        checks++;
        if (ra !== {10'b0, a[7:2]}) begin failures++; $display("FAIL rand_addr a=%h got=%h exp=%h", a, ra, {10'b0, a[7:2]}); end
      end
      if (ewc > 0) begin
        checks++;
        if (wd !== mw) begin failures++; $display("FAIL rand_wdata a=%h f3=%b got=%h exp=%h", a, f3, wd, mw); end
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    for (int w = 0; w < 64; w++) set_word(w, $urandom);
    test_lw();
    test_load_ext();
    test_sb();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the core's MEM stage and the word-organised data `spram`. It accepts one RISC-V load or store at a time and issues only full-word RAM accesses (`rwtyp` = 3'b010). It implements byte and halfword stores as read-modify-write, and performs lane extraction and sign or zero extension for loads. Misaligned and illegal accesses are rejected without touching the RAM.

## Interface
- `RAM_ADDR_WIDTH`, default 16: word-address width of the attached `spram`.
- `DATA_WIDTH`, default 32: data word width; fixed at 32 for RV32.
- `clk` input 1: single clock; everything is sampled on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller idle; a request is accepted when `req_valid && req_ready`.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `rsp_valid` output 1: one-cycle completion pulse.
- `rsp_rdata` output 32: load result, extended; 0 for stores and errors.
- `rsp_err` output 1: misaligned or illegal funct3; qualified by `rsp_valid`.
- `ram_address` output RAM_ADDR_WIDTH: `req_addr[RAM_ADDR_WIDTH+1:2]`, taken from the latched request.
- `ram_rden` output 1: RAM read enable.
- `ram_wren` output 1: RAM write enable.
- `ram_data` output 32: full word to write.
- `ram_rwtyp` output 3: constant 3'b010.
- `ram_q` input 32: RAM read data, valid one cycle after `ram_rden`.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - RD: `ram_rden`=1.
  - MERGE: `ram_wren`=1, merged data.
  - WR: `ram_wren`=1, `req_wdata`.
  - LDRSP: extract the load result from `ram_q`.
  - RESP: pulse `rsp_valid`.
- On accept, latch `req_we`, `req_funct3`, `req_addr` and `req_wdata`, then branch:
  - Error (half with `addr[0]`=1, word with `addr[1:0]`≠0, or funct3 011/110/111 for loads, or anything other than 000/001/010 for stores): go to RESP with `rsp_err`=1.
  - Load: IDLE → RD → LDRSP. `rsp_valid` is asserted in LDRSP, then return to IDLE.
  - SW: IDLE → WR → RESP.
  - SB/SH: IDLE → RD → MERGE → RESP.
- Load lane extraction: byte lane = `addr[1:0]`, half lane = `addr[1]`.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- Store merge:
  - Take `ram_q` and replace the addressed byte with `req_wdata[7:0]`, or the addressed half with `req_wdata[15:0]`.
  - The merge is computed combinationally in MERGE; `ram_data` is the merged word.
- Address bits above `RAM_ADDR_WIDTH+1` are ignored, so addresses alias modulo the RAM size.
- `req_valid` is ignored outside IDLE. `req_*` do not need to stay stable after accept.
- There is no response back-pressure: the MEM stage stalls on `req_ready`.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready`=0 while `rst`=1, 1 from the first cycle after reset.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `ram_rden`=0, `ram_wren`=0, `ram_data`=0, `ram_address`=0.
- Latency from the accept edge (cycle 0) to `rsp_valid`:
  - Error: cycle 1.
  - Load: cycle 2.
  - SW: cycle 2.
  - SB/SH: cycle 3.
- Back-to-back requests: the next request can be accepted in the cycle after `rsp_valid`, so the minimum issue interval equals latency + 1.
- A read-modify-write never interleaves with another request; atomicity is guaranteed by the single-outstanding rule.
- `ram_rden` and `ram_wren` are never asserted together.
- Reset mid-operation: the next edge returns to IDLE with no response. A write whose `ram_wren` cycle coincides with `rst`=1 is undefined, and software treats it as lost.
- All outputs are combinational decodes of registered state and latched request only, never of `req_*`.

## Structure
- `lsu_pkg` holds:
  - The `lsu_state_e` enum.
  - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - `RWTYP_WORD`=3'b010.
- Sub-module `lsu_lane`: purely combinational. Inputs are `word`, `addr[1:0]`, `funct3` and `wdata`; outputs are `load_data` and `merged_word`. It is shared by the LDRSP and MERGE paths.
- `lsu_ctrl` contains the FSM, the request latch and the RAM port drive.

## Test plan
- LW at 0x0000_0010 with RAM word[4]=0xDEADBEEF: `ram_rden` in cycle 1 with `ram_address`=4; `rsp_valid` in cycle 2 with `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- LB/LBU at 0x13 and LH/LHU at 0x12 on word 0x80FF7F01: LB → 0xFFFFFF80, LBU → 0x00000080, LH → 0xFFFF80FF, LHU → 0x000080FF.
- SB 0xAA at 0x21 over word 0x11223344: read in cycle 1, write 0x1122AA44 in cycle 2, `rsp_valid` in cycle 3. A following LW returns 0x1122AA44.
- Misaligned LW at 0x2 and SH at 0x5: no `ram_rden`/`ram_wren` ever; `rsp_valid`=1 and `rsp_err`=1 in cycle 1; `rsp_rdata`=0.
- Back-to-back SW then LW to the same address with `req_valid` held high: `req_ready`=0 during SW, LW accepted the cycle after the SW response, and LW returns the stored value.
- `rst` asserted in MERGE of an SH: no `rsp_valid`, IDLE next cycle, `req_ready`=1 once reset drops, and outputs at their reset values.
